// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: digit-scan prescaler and frame-aligned shadow update for the
// 4-digit time-multiplexed seven-segment decode path.
//
// state    | meaning
// ST_EMPTY | no update pending, write port ready
// ST_FULL  | update captured, waiting for a frame boundary (or en low) to apply
module sseg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] wr_data,
    input  logic        wr_hex_dec,
    input  logic        wr_sign,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [15:0] data,
    output logic        hex_dec,
    output logic        sign,
    output logic [1:0]  digit_sel,
    output logic        frame_tick
);

    localparam int            CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [0:0]    ST_EMPTY = 1'b0;
    localparam logic [0:0]    ST_FULL  = 1'b1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic          tick_q, tick_d;
    logic [0:0]    state_q, state_d;
    logic [15:0]   pend_data_q, pend_data_d;
    logic          pend_hex_q, pend_hex_d;
    logic          pend_sign_q, pend_sign_d;
    logic [15:0]   data_q, data_d;
    logic          hex_q, hex_d;
    logic          sign_q, sign_d;

    logic step;
    logic boundary;
    logic accept;
    logic apply;

    assign step     = en && (cnt_q == CNT_MAX);
    assign boundary = step && (digit_q == 2'd3);
    assign accept   = wr_valid && (state_q == ST_EMPTY);
    // With the scan frozen no frame is in progress, so the update may land at once.
    assign apply    = (state_q == ST_FULL) && (boundary || !en);

    always_comb begin
        cnt_d   = cnt_q;
        digit_d = digit_q;
        if (en) begin
            if (step) begin
                cnt_d   = '0;
                digit_d = digit_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        tick_d = boundary;
    end

    always_comb begin
        state_d     = state_q;
        pend_data_d = pend_data_q;
        pend_hex_d  = pend_hex_q;
        pend_sign_d = pend_sign_q;
        data_d      = data_q;
        hex_d       = hex_q;
        sign_d      = sign_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    pend_data_d = wr_data;
                    pend_hex_d  = wr_hex_dec;
                    pend_sign_d = wr_sign;
                    state_d     = ST_FULL;
                end
            end
            ST_FULL: begin
                if (apply) begin
                    data_d  = pend_data_q;
                    hex_d   = pend_hex_q;
                    sign_d  = pend_sign_q;
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            digit_q     <= 2'd0;
            tick_q      <= 1'b0;
            state_q     <= ST_EMPTY;
            pend_data_q <= 16'h0000;
            pend_hex_q  <= 1'b1;
            pend_sign_q <= 1'b0;
            data_q      <= 16'h0000;
            hex_q       <= 1'b1;
            sign_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            digit_q     <= digit_d;
            tick_q      <= tick_d;
            state_q     <= state_d;
            pend_data_q <= pend_data_d;
            pend_hex_q  <= pend_hex_d;
            pend_sign_q <= pend_sign_d;
            data_q      <= data_d;
            hex_q       <= hex_d;
            sign_q      <= sign_d;
        end
    end

    assign wr_ready   = (state_q == ST_EMPTY);
    assign data       = data_q;
    assign hex_dec    = hex_q;
    assign sign       = sign_q;
    assign digit_sel  = digit_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Testbench for sseg_scan_ctrl with REFRESH_DIV = 4 (16-cycle frame); every
// cycle is compared against a model built from enabled-cycle counting.
module tb_sseg_scan_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk, rst, en;
    logic [15:0] wr_data;
    logic        wr_hex_dec, wr_sign, wr_valid, wr_ready;
    logic [15:0] data;
    logic        hex_dec, sign, frame_tick;
    logic [1:0]  digit_sel;

    int n_checks;
    int n_errors;
    int cyc;

    // Reference model: scan position derived from count of enabled edges.
    int          m_en_cycles;
    bit          m_pend;
    logic [15:0] m_pd, m_data;
    bit          m_phex, m_psign, m_hex, m_sign, m_tick;

    sseg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .en(en),
        .wr_data(wr_data), .wr_hex_dec(wr_hex_dec), .wr_sign(wr_sign),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .data(data), .hex_dec(hex_dec), .sign(sign),
        .digit_sel(digit_sel), .frame_tick(frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [21:0] model_vec();
        return {2'((m_en_cycles / DIV) % 4), m_tick, ~m_pend, m_hex, m_sign, m_data};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {digit_sel, frame_tick, wr_ready, hex_dec, sign, data};
    endfunction

    task automatic model_reset();
        m_en_cycles = 0;
        m_pend      = 1'b0;
        m_pd        = 16'h0;
        m_phex      = 1'b1;
        m_psign     = 1'b0;
        m_data      = 16'h0;
        m_hex       = 1'b1;
        m_sign      = 1'b0;
        m_tick      = 1'b0;
        cyc         = 0;
    endtask

    task automatic tick();
        logic s_en, s_v, s_h, s_s;
        logic [15:0] s_d;
        bit bnd, acc, app;
        s_en = en; s_v = wr_valid; s_h = wr_hex_dec; s_s = wr_sign; s_d = wr_data;
        @(posedge clk);
        #1;
        bnd = s_en && (((m_en_cycles + 1) % FRAME) == 0);
        acc = s_v && !m_pend;
        app = m_pend && (bnd || !s_en);
        if (app) begin
            m_data = m_pd; m_hex = m_phex; m_sign = m_psign; m_pend = 1'b0;
        end else if (acc) begin
            m_pd = s_d; m_phex = s_h; m_psign = s_s; m_pend = 1'b1;
        end
        m_tick = bnd;
        if (s_en) m_en_cycles++;
        cyc++;
    endtask

    task automatic do_reset();
        en = 1'b0; wr_valid = 1'b0; wr_data = 16'h0; wr_hex_dec = 1'b0; wr_sign = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        en = 1'b0; wr_valid = 1'b1; wr_data = 16'hBEEF; wr_hex_dec = 1'b0; wr_sign = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        wr_valid = 1'b1; wr_data = 16'h1111; wr_hex_dec = 1'b1; wr_sign = 1'b0;
        tick();
        wr_valid = 1'b0;
        tick(); tick();
        n_checks++;
        if (dut_vec() !== model_vec()) begin
            n_errors++;
            $display("FAIL reset_pre: got %h expected %h", dut_vec(), model_vec());
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (dut_vec() !== {2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000}) begin
            n_errors++;
            $display("FAIL reset_async: got %h expected %h", dut_vec(),
                     {2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (digit_sel !== ((i == 4) ? 2'd1 : 2'd0)) begin
                n_errors++;
                $display("FAIL reset_first_step edge=%0d: got %0d expected %0d", i, digit_sel,
                         (i == 4) ? 1 : 0);
            end
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL reset_release cyc=%0d: got %h expected %h", cyc, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_free_scan();
        int ticks;
        ticks = 0;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (frame_tick === 1'b1) ticks++;
            n_checks++;
            if (digit_sel !== 2'((i / DIV) % 4)) begin
                n_errors++;
                $display("FAIL free_digit cyc=%0d: got %0d expected %0d", i, digit_sel, (i / DIV) % 4);
            end
            n_checks++;
            if (frame_tick !== ((i == 16) || (i == 32))) begin
                n_errors++;
                $display("FAIL free_tick cyc=%0d: got %b expected %b", i, frame_tick, (i == 16) || (i == 32));
            end
        end
        n_checks++;
        if (ticks != 2) begin
            n_errors++;
            $display("FAIL free_tick_count: got %0d expected 2", ticks);
        end
    endtask

    task automatic test_frame_update();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        wr_valid = 1'b1; wr_data = 16'h1234; wr_hex_dec = 1'b1; wr_sign = 1'b0;
        tick();
        wr_valid = 1'b0;
        n_checks++;
        if (wr_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL update_ready_low: got %b expected 0", wr_ready);
        end
        while (cyc < 20) begin
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL update_vec cyc=%0d: got %h expected %h", cyc, dut_vec(), model_vec());
            end
            n_checks++;
            if (data !== ((cyc >= 16) ? 16'h1234 : 16'h0000)) begin
                n_errors++;
                $display("FAIL update_data cyc=%0d: got %h expected %h", cyc, data,
                         (cyc >= 16) ? 16'h1234 : 16'h0000);
            end
            n_checks++;
            if (wr_ready !== (cyc >= 16)) begin
                n_errors++;
                $display("FAIL update_ready cyc=%0d: got %b expected %b", cyc, wr_ready, cyc >= 16);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1'b1;
        wr_valid = 1'b1; wr_data = 16'hABCD; wr_hex_dec = 1'b1; wr_sign = 1'b0;
        tick();
        wr_data = 16'h0042;
        while (cyc < 36) begin
            tick();
            if (cyc == 17) wr_valid = 1'b0;
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL b2b_vec cyc=%0d: got %h expected %h", cyc, dut_vec(), model_vec());
            end
            if (cyc == 15 || cyc == 16 || cyc == 31 || cyc == 32) begin
                n_checks++;
                if (data !== ((cyc < 16) ? 16'h0000 : (cyc < 32) ? 16'hABCD : 16'h0042)) begin
                    n_errors++;
                    $display("FAIL b2b_data cyc=%0d: got %h", cyc, data);
                end
            end
        end
    endtask

    task automatic test_enable_low();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        en = 1'b0;
        wr_valid = 1'b1; wr_data = 16'h00FF; wr_hex_dec = 1'b0; wr_sign = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        n_checks++;
        if ({data, sign, hex_dec} !== {16'h00FF, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL enlow_apply: got %h/%b expected 00ff/1", data, sign);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (digit_sel !== 2'd2) begin
                n_errors++;
                $display("FAIL enlow_frozen: got %0d expected 2", digit_sel);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL enlow_resume cyc=%0d: got %h expected %h", cyc, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_boundary_collision();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        wr_valid = 1'b1; wr_data = 16'h5A5A; wr_hex_dec = 1'b0; wr_sign = 1'b1;
        tick();
        wr_valid = 1'b0;
        n_checks++;
        if ({frame_tick, wr_ready, data} !== {1'b1, 1'b0, 16'h0000}) begin
            n_errors++;
            $display("FAIL collide_edge: got %b/%b/%h expected 1/0/0000", frame_tick, wr_ready, data);
        end
        while (cyc < 32) begin
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL collide_vec cyc=%0d: got %h expected %h", cyc, dut_vec(), model_vec());
            end
        end
        n_checks++;
        if ({data, sign, wr_ready} !== {16'h5A5A, 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL collide_apply: got %h/%b/%b expected 5a5a/1/1", data, sign, wr_ready);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            en         = ($urandom_range(0, 9) != 0);
            wr_valid   = ($urandom_range(0, 3) == 0);
            wr_data    = 16'($urandom);
            wr_hex_dec = 1'($urandom);
            wr_sign    = 1'($urandom);
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL random_vec cyc=%0d: got %h expected %h", cyc, dut_vec(), model_vec());
            end
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_data = 16'h0; wr_hex_dec = 1'b0; wr_sign = 1'b0;
        model_reset();
        test_reset();
        test_free_scan();
        test_frame_update();
        test_back_to_back();
        test_enable_low();
        test_boundary_collision();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

Refresh and update controller for the 4-digit time-multiplexed seven-segment display path. It generates the `digit_sel` scan sequence from a programmable prescaler and holds the display word, the `hex_dec` mode and the `sign` flag in shadow registers. New values are accepted through a valid/ready write port and are applied only at a frame boundary, so a scan frame never mixes old and new digits. It sits between the system logic that produces display values and the combinational `sseg4_TDM` decode path, whose `data`, `hex_dec`, `sign` and `digit_sel` inputs it drives directly.

## Interface

Parameters:

- `REFRESH_DIV`, default 100000, clock cycles per digit slot; 1 kHz digit rate at 100 MHz. Legal range is 2 or more. The prescaler width is `$clog2(REFRESH_DIV)`.

Ports (name, direction, width, meaning):

- `clk`, input, 1, system clock. All state changes on its rising edge.
- `rst`, input, 1, reset. Asynchronous, active-high.
- `en`, input, 1, scan enable. When low, the prescaler and `digit_sel` hold.
- `wr_data`, input, 16, new display word.
- `wr_hex_dec`, input, 1, new mode. 1 = raw hex, 0 = BCD of `wr_data[10:0]`.
- `wr_sign`, input, 1, new sign flag. 1 = show minus on the leftmost digit.
- `wr_valid`, input, 1, write request.
- `wr_ready`, output, 1, write slot free (no pending update).
- `data`, output, 16, shadow display word.
- `hex_dec`, output, 1, shadow mode.
- `sign`, output, 1, shadow sign.
- `digit_sel`, output, 2, current digit slot, 0 = rightmost.
- `frame_tick`, output, 1, one-cycle pulse on each frame boundary.

## Operation

- **Prescaler `cnt`**
  - When `en`=1: if `cnt == REFRESH_DIV-1`, `cnt` returns to 0 and internal `step` = 1. Otherwise `cnt` increments and `step` = 0.
  - When `en`=0: `cnt` holds and `step` = 0.
- **Digit counter:** on a `step` edge, `digit_sel` advances 0→1→2→3→0, wrapping modulo 4.
- **Frame boundary:** the edge where `step` = 1 and `digit_sel` = 3. On that edge `frame_tick` is registered high for exactly one cycle, coinciding with `digit_sel` becoming 0.
- **Write port (single pending slot)**
  - `wr_ready` = ~`pend_full`.
  - The transfer occurs on an edge where `wr_valid` & `wr_ready`. It captures `wr_data`, `wr_hex_dec` and `wr_sign` into the pending registers and sets `pend_full`.
  - `wr_valid` while `wr_ready` = 0 is ignored. The requester must hold the request. Nothing is overwritten.
- **Apply (pending → shadow)**
  - Occurs when `pend_full` = 1 and either:
    - it is a frame-boundary edge, or
    - `en` = 0 (display frozen, no frame in progress), in which case apply happens on the next edge.
  - On apply, the shadow registers are loaded and `pend_full` clears.
- **Simultaneous events:** on a boundary edge with `pend_full` = 0, an accepted write goes to pending only. It is applied at the following boundary, never in the same edge.
- **Outputs are registers:** `data`, `hex_dec`, `sign` and `digit_sel` change only on clock edges. They do not depend combinationally on any input.
- **Reset (any time, including mid-frame or with an update pending):**
  - `cnt` = 0, `digit_sel` = 0, `frame_tick` = 0.
  - `data` = 16'h0000, `hex_dec` = 1, `sign` = 0.
  - `pend_full` = 0, so `wr_ready` = 1. Any pending write is discarded.

## Timing

- **Digit slot:** exactly `REFRESH_DIV` enabled cycles.
- **Frame:** 4·`REFRESH_DIV` enabled cycles.
- **`frame_tick`:** period 4·`REFRESH_DIV` with `en` held high; width 1 cycle.
- **First `digit_sel` change after reset release:** the `REFRESH_DIV`-th enabled edge.
- **Write latency, acceptance to shadow update:**
  - `en` = 1: from 1 cycle up to 4·`REFRESH_DIV` cycles.
  - `en` = 0: 1 cycle.
- **`wr_ready`:** falls on the edge after acceptance. It rises on the apply edge, so a new write can be accepted on the next edge.
- **Throughput:** at most one update per frame while scanning.

## Test plan

Benches use `REFRESH_DIV` = 4, giving a 16-cycle frame.

1. **Reset.** Assert `rst` mid-frame with a pending write → all outputs at their reset values immediately, without waiting for a clock. After release, the first `digit_sel` = 1 appears on the 4th edge.
2. **Free-running scan.** `en` = 1 for 40 cycles → `digit_sel` follows 0,0,0,0,1,1,1,1,2,…. `frame_tick` pulses at cycles 16 and 32, each coincident with `digit_sel` returning to 0.
3. **Frame-aligned update.** Write 16'h1234 / `hex_dec` 1 / `sign` 0 at cycle 5 → `wr_ready` low from cycle 6. `data` stays 0 until the cycle-16 boundary, then becomes 16'h1234, and `wr_ready` returns high.
4. **Back-pressure.** Write 16'hABCD, then hold `wr_valid` with 16'h0042 → the second write is ignored until `wr_ready` rises. `data` shows ABCD at the first boundary and 0042 at the next.
5. **Enable low.** Set `en` = 0 at `digit_sel` = 2, then write 16'h00FF with `sign` 1 → `digit_sel` and `cnt` frozen, `data` = 16'h00FF and `sign` = 1 one cycle after acceptance. Scanning resumes from the same slot when `en` = 1.
6. **Boundary collision.** Assert `wr_valid` on the exact boundary edge with no pending write → the write is accepted but not applied that edge. It is applied at the next boundary, 16 cycles later.
